// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment display path.
//   - Segment bit order of the 7-bit bus: {a,b,c,d,e,f,g}, a in bit 6.
//   - SEG7_HEX: active-low glyph for each hex value, indexed by the value.
//     The display decoder uses this table, and the capture monitor uses it too.
//   - cap_state_t: state encoding of the bus capture FSM.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG7_HEX [0:15] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex
// Combinational inverse of the display decoder. It maps an active-low segment
// pattern back to its hex nibble.
// Ports:
//   i_seg_n   in  7  segments {a,b,c,d,e,f,g}, active-low
//   o_legal   out 1  pattern matches one of the 16 hex glyphs
//   o_nibble  out 4  recovered value (0 when not legal)
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    // All glyphs are distinct, so at most one entry can match.
    always_comb begin
        o_legal  = 1'b0;
        o_nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (i_seg_n == SEG7_HEX[k]) begin
                o_legal  = 1'b1;
                o_nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg7_bus_capture.sv
// seg7_bus_capture
// Monitor that snoops a multiplexed active-low seven-segment bus and recovers
// the hex value of each digit. A pattern is captured only after it has been
// stable for STABLE_CYCLES samples. The block also flags non-hex glyphs and
// multi-enable glitches, and it pulses when every digit has been captured.
// Ports:
//   i_clk          in  1             clock
//   i_rst          in  1             asynchronous active-high reset
//   i_seg_n        in  7             segments {a..g}, active-low
//   i_an_n         in  NUM_DIGITS    digit enables, active-low
//   o_digits       out 4*NUM_DIGITS  recovered nibbles, digit i at [4i+3:4i]
//   o_digit_valid  out NUM_DIGITS    digit has had a legal capture
//   o_pattern_err  out NUM_DIGITS    last capture of digit was not a hex glyph
//   o_bus_err      out 1             pulse: more than one enable low
//   o_frame_done   out 1             pulse: every digit captured since last pulse
//
// state  | meaning
// IDLE   | no enable or several enables low; counter held at 0
// SETTLE | one enable low; counting identical consecutive samples
// HOLD   | sample captured; waiting for the bus to change
module seg7_bus_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_seg_n,
    input  logic [NUM_DIGITS-1:0]   i_an_n,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic [NUM_DIGITS-1:0]   o_pattern_err,
    output logic                    o_bus_err,
    output logic                    o_frame_done
);

    localparam int         SW     = NUM_DIGITS + 7;
    localparam int         IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [SW-1:0]           r_sample;
    logic [SW-1:0]           r_sample_d;
    logic                    r_primed;
    cap_state_t              r_state;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    r_bus_err;
    logic                    r_frame_done;

    logic [NUM_DIGITS-1:0]   w_low;
    logic [6:0]              w_seg_n;
    logic                    w_one_hot;
    logic                    w_multi;
    logic                    w_changed;
    logic [IW-1:0]           w_idx;
    logic                    w_legal;
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_mask_set;
    cap_state_t              w_state_nxt;
    logic [7:0]              w_cnt_nxt;
    logic                    w_capture;

    // The sample register resets to all-zero, and that value would look like
    // every digit enabled. r_primed masks the single cycle before the first
    // real sample, so the reset value cannot raise bus_err.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample   <= '0;
            r_sample_d <= '0;
            r_primed   <= 1'b0;
        end else begin
            r_sample   <= {i_an_n, i_seg_n};
            r_sample_d <= r_sample;
            r_primed   <= 1'b1;
        end
    end

    assign w_low     = ~r_sample[SW-1:7];
    assign w_seg_n   = r_sample[6:0];
    assign w_one_hot = r_primed && ($countones(w_low) == 1);
    assign w_multi   = r_primed && ($countones(w_low) > 1);
    assign w_changed = (r_sample != r_sample_d);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_low[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    seg7_to_hex u_dec (
        .i_seg_n  (w_seg_n),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds the number of identical consecutive samples seen before the
    // current one. w_cnt_nxt therefore includes the sample in r_sample now.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_one_hot) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!w_one_hot) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    if (w_changed) begin
                        w_cnt_nxt = 8'd1;
                    end else if (r_cnt < STABLE) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                    if (w_cnt_nxt == STABLE) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!w_one_hot) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_changed) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_mask_set = r_mask | (NUM_DIGITS'(1) << w_idx);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digits     <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_mask       <= '0;
            r_bus_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_bus_err    <= w_multi;
            r_frame_done <= 1'b0;
            if (w_capture) begin
                if (w_legal) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_nibble;
                    r_valid[w_idx]                <= 1'b1;
                    r_err[w_idx]                  <= 1'b0;
                end else begin
                    r_err[w_idx]                  <= 1'b1;
                end
                // An illegal capture still counts toward the frame.
                if (&w_mask_set) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask       <= w_mask_set;
                end
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_valid;
    assign o_pattern_err = r_err;
    assign o_bus_err     = r_bus_err;
    assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg7_bus_capture.sv
// tb_seg7_bus_capture
// Directed bench for seg7_bus_capture: table of hex glyphs on digit 0 plus
// hand-written sequences for reset, glitch filtering, frames and bus errors.
module tb_seg7_bus_capture;

    localparam int ND = 4;
    localparam int SC = 8;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dv;
    logic [3:0]  perr;
    logic        bus_err;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int be_cnt = 0;
    bit mon1 = 1'b0;
    bit saw1 = 1'b0;

    vec_t       vecs [18];
    logic [6:0] pats [4];

    always #5 clk = ~clk;

    seg7_bus_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_seg_n       (seg_n),
        .i_an_n        (an_n),
        .o_digits      (digits),
        .o_digit_valid (dv),
        .o_pattern_err (perr),
        .o_bus_err     (bus_err),
        .o_frame_done  (frame_done)
    );

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (bus_err) be_cnt++;
        if (mon1 && digits[3:0] == 4'h1) saw1 = 1'b1;
    end

    // Lands 1 time unit after the n-th falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{7'h01, 4'h0, 1'b0};
        vecs[1]  = '{7'h4F, 4'h1, 1'b0};
        vecs[2]  = '{7'h12, 4'h2, 1'b0};
        vecs[3]  = '{7'h06, 4'h3, 1'b0};
        vecs[4]  = '{7'h4C, 4'h4, 1'b0};
        vecs[5]  = '{7'h24, 4'h5, 1'b0};
        vecs[6]  = '{7'h7F, 4'h5, 1'b1};
        vecs[7]  = '{7'h20, 4'h6, 1'b0};
        vecs[8]  = '{7'h0F, 4'h7, 1'b0};
        vecs[9]  = '{7'h00, 4'h8, 1'b0};
        vecs[10] = '{7'h04, 4'h9, 1'b0};
        vecs[11] = '{7'h08, 4'hA, 1'b0};
        vecs[12] = '{7'h60, 4'hB, 1'b0};
        vecs[13] = '{7'h31, 4'hC, 1'b0};
        vecs[14] = '{7'h42, 4'hD, 1'b0};
        vecs[15] = '{7'h30, 4'hE, 1'b0};
        vecs[16] = '{7'h38, 4'hF, 1'b0};
        vecs[17] = '{7'h7E, 4'hF, 1'b1};
        pats[0] = 7'h4F;
        pats[1] = 7'h08;
        pats[2] = 7'h0F;
        pats[3] = 7'h38;

        // Reset state
        step(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_flags", 32'({bus_err, frame_done}), 32'h0);
        rst = 1'b0;
        step(2);
        chk("post_rst_buserr", 32'(bus_err), 32'h0);

        // Basic capture on digit 0
        an_n = 4'b1110; seg_n = 7'h12;
        step(8);
        chk("basic_before", 32'(dv), 32'h0);
        step(1);
        chk("basic_digit", 32'(digits[3:0]), 32'h2);
        chk("basic_valid", 32'(dv), 32'h1);
        step(100);
        chk("basic_hold_digit", 32'(digits), 32'h2);
        chk("basic_hold_valid", 32'(dv), 32'h1);

        // Glitch filter: 7 samples of "1" then "3"
        mon1 = 1'b1;
        seg_n = 7'h4F;
        step(7);
        seg_n = 7'h06;
        step(8);
        chk("glitch_before", 32'(digits[3:0]), 32'h2);
        step(1);
        chk("glitch_digit", 32'(digits[3:0]), 32'h3);
        mon1 = 1'b0;
        chk("glitch_never1", 32'(saw1), 32'h0);

        // Asynchronous reset mid-cycle
        an_n = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("async_digits", 32'(digits), 32'h0);
        chk("async_valid", 32'(dv), 32'h0);
        chk("async_flags", 32'({perr, bus_err, frame_done}), 32'h0);
        step(1);
        rst = 1'b0;
        step(2);
        chk("async_release_valid", 32'(dv), 32'h0);

        // Full frame 0x1, 0xA, 0x7, 0xF with blank gaps
        fd_cnt = 0;
        for (int d = 0; d < 4; d++) begin
            an_n = ~(4'b0001 << d);
            seg_n = pats[d];
            step(9);
            chk("frame_pulse", 32'(frame_done), (d == 3) ? 32'h1 : 32'h0);
            step(1);
            an_n = 4'hF;
            step(2);
        end
        chk("frame_digits", 32'(digits), 32'hF7A1);
        chk("frame_valid", 32'(dv), 32'hF);
        chk("frame_count", 32'(fd_cnt), 32'h1);

        // Illegal glyph on digit 1
        an_n = 4'b1101; seg_n = 7'h7F;
        step(9);
        chk("illegal_perr", 32'(perr), 32'h2);
        chk("illegal_digit", 32'(digits[7:4]), 32'hA);
        chk("illegal_valid", 32'(dv), 32'hF);
        an_n = 4'hF;
        step(2);

        // Two enables low
        be_cnt = 0;
        an_n = 4'b1100; seg_n = 7'h12;
        step(5);
        an_n = 4'hF;
        step(3);
        chk("buserr_count", 32'(be_cnt), 32'h5);
        chk("buserr_digits", 32'(digits), 32'hF7A1);
        chk("buserr_perr", 32'(perr), 32'h2);

        // Legal capture clears the pattern error
        an_n = 4'b1101; seg_n = 7'h24;
        step(9);
        chk("clear_digit", 32'(digits[7:4]), 32'h5);
        chk("clear_perr", 32'(perr), 32'h0);
        an_n = 4'hF;
        step(2);

        // Reset during settle discards the partial count
        an_n = 4'b1011; seg_n = 7'h04;
        step(5);
        #2 rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        chk("midrst_3", 32'(dv), 32'h0);
        step(5);
        chk("midrst_8", 32'(dv), 32'h0);
        step(1);
        chk("midrst_valid", 32'(dv), 32'h4);
        chk("midrst_digit", 32'(digits[11:8]), 32'h9);
        an_n = 4'hF;
        step(2);

        // Full glyph table on digit 0
        for (int v = 0; v < 18; v++) begin
            an_n = 4'hF;
            step(2);
            an_n = 4'b1110; seg_n = vecs[v].seg;
            step(9);
            chk("tbl_digit", 32'(digits[3:0]), 32'(vecs[v].nib));
            chk("tbl_valid", 32'(dv[0]), 32'h1);
            chk("tbl_perr", 32'(perr[0]), 32'(vecs[v].err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
